hilo_div_sequencer: RTL

Multi-cycle sequencer for the unsigned divider and HI/LO register pair in the EX stage of the MIPS pipeline. Detects DIVU in EX, pulses the divider start, counts the fixed divide latency, then commits the 64-bit quotient/remainder to HI/LO with a one-cycle write strobe. While a divide is outstanding it stalls any DIVU, MFHI or MFLO that reaches EX, so HI/LO reads always see a completed result. ALU, shifter and other non-HI/LO instructions proceed unstalled.

---
 rtl/alu_ctrl_pkg.sv | 26 ++
 rtl/div_cycle_counter.sv | 27 ++
 rtl/hilo_div_sequencer.sv | 85 ++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// EX-stage control constants shared by the ALU, shifter and HI/LO divide sequencer.
// Holds the R-type funct codes, the divide FSM state encoding and a HI/LO-op decode helper.
package alu_ctrl_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_MFHI = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO = 6'b010010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic isHiloFunct(input logic [5:0] funct);
    return (funct == FUNCT_DIVU) || (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO);
  endfunction

endpackage

// File: rtl/div_cycle_counter.sv
// Loadable down-counter with zero flag; load wins over decrement, saturates at zero.
// Single-cycle update, no flow control.
module div_cycle_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/hilo_div_sequencer.sv
// DIVU/HI-LO sequencer: start pulse, DIV_CYCLES run, one-cycle hilo_we; stalls HI/LO ops while busy.
// Optional HILO_DIV_ZERO_SKIP_EN: divide by zero goes straight to the write-back cycle.
module hilo_div_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [5:0]       ex_funct,
  input  logic             divisor_zero,
  output logic             div_start,
  output logic [5:0]       div_signal,
  output logic             hilo_we,
  output logic             stall,
  output logic             busy,
  output logic [CNT_W-1:0] cycles_left
);

  logic [1:0]       state;
  logic [1:0]       stateNext;
  logic             hiloOp;
  logic             divuInEx;
  logic             issue;
  logic             skipRun;
  logic             cntLoad;
  logic             cntZero;
  logic [CNT_W-1:0] cntValue;

  assign hiloOp   = ex_valid && isHiloFunct(ex_funct);
  assign divuInEx = ex_valid && (ex_funct == FUNCT_DIVU);

`ifdef HILO_DIV_ZERO_SKIP_EN
  assign skipRun = divisor_zero;
`else
  logic unusedDivisorZero;
  assign unusedDivisorZero = divisor_zero;
  assign skipRun = 1'b0;
`endif

  // Outputs are held quiet during the reset cycle so nothing launches into an aborted state.
  assign issue   = !reset && (state == ST_IDLE) && divuInEx;
  assign cntLoad = issue && !skipRun;

  div_cycle_counter #(
    .CNT_W(CNT_W)
  ) uCounter (
    .clk      (clk),
    .reset    (reset),
    .load     (cntLoad),
    .loadValue(CNT_W'(DIV_CYCLES - 1)),
    .dec      (state == ST_RUN),
    .count    (cntValue),
    .zero     (cntZero)
  );

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: if (issue) stateNext = skipRun ? ST_DONE : ST_RUN;
      ST_RUN:  if (cntZero) stateNext = ST_DONE;
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  assign busy        = (state != ST_IDLE);
  assign hilo_we     = (state == ST_DONE);
  assign div_start   = issue;
  assign div_signal  = (issue || (state == ST_RUN)) ? FUNCT_DIVU : 6'b0;
  // HI/LO is only written at the end of DONE, so readers stay frozen through that cycle.
  assign stall       = !reset && busy && hiloOp;
  assign cycles_left = (state == ST_RUN) ? cntValue : '0;

endmodule
